// File: rtl/dec_rr_arbiter_pkg.sv
// Shared constants, FSM encoding and helpers for the round-robin arbiter.
package dec_rr_arbiter_pkg;

  localparam int unsigned N_REQ    = 16;
  localparam int unsigned IDX_W    = 4;
  localparam int unsigned MAX_HOLD = 8;
  // Counter only has to reach MAX_HOLD-1; keep at least one bit when disabled.
  localparam int unsigned HOLD_W   = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GUARD = 2'd2
  } state_e;

  // Index of the requester after idx, wrapping 15 -> 0.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return IDX_W'((32'(idx) + 32'd1) % N_REQ);
  endfunction

endpackage : dec_rr_arbiter_pkg

// File: rtl/dec_rr_arbiter_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface dec_rr_arbiter_if;
  import dec_rr_arbiter_pkg::*;

  logic [N_REQ-1:0] req;
  logic             done;
  logic [N_REQ-1:0] gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_valid;

  modport master (
    output req,
    output done,
    input  gnt,
    input  gnt_idx,
    input  gnt_valid
  );

  modport slave (
    input  req,
    input  done,
    output gnt,
    output gnt_idx,
    output gnt_valid
  );

endinterface : dec_rr_arbiter_if

// File: rtl/dec_rr_arbiter_dec4to16.sv
// 4-to-16 one-hot decoder with enable; all zero when disabled.
module dec_rr_arbiter_dec4to16 (
  input  logic [3:0]  w,
  input  logic        en,
  output logic [15:0] y_c
);

  // Shift a single one into position w when enabled.
  always_comb begin
    y_c = '0;
    if (en) begin
      y_c = 16'(16'd1 << w);
    end
  end

endmodule : dec_rr_arbiter_dec4to16

// File: rtl/dec_rr_arbiter.sv
// Round-robin arbiter over 16 requesters with a hold limit and a one-cycle
// break-before-make gap between grants.
module dec_rr_arbiter
  import dec_rr_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  dec_rr_arbiter_if.slave  bus
);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic               gnt_valid_q, gnt_valid_d;

  logic               scan_found_c;
  logic [IDX_W-1:0]   scan_win_c;
  logic [IDX_W-1:0]   scan_cand_c;
  logic               hold_limit_c;
  logic               release_c;

  // Rotating-priority scan: first set request starting at ptr, wrapping mod 16.
  always_comb begin
    scan_found_c = 1'b0;
    scan_win_c   = '0;
    scan_cand_c  = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      scan_cand_c = IDX_W'((32'(ptr_q) + k) % N_REQ);
      if (!scan_found_c && bus.req[scan_cand_c]) begin
        scan_found_c = 1'b1;
        scan_win_c   = scan_cand_c;
      end
    end
  end

  // Release on done, on the grantee dropping its request, or on the hold limit.
  always_comb begin
    hold_limit_c = 1'b0;
    if (MAX_HOLD != 0) begin
      hold_limit_c = (hold_cnt_q == HOLD_W'(MAX_HOLD - 1));
    end
    release_c = bus.done | ~bus.req[gnt_idx_q] | hold_limit_c;
  end

  // Next-state logic. The guard cycle already drives zero grants, so it also
  // arbitrates; this keeps the gap between grants to a single cycle.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    gnt_idx_d  = gnt_idx_q;
    unique case (state_q)
      ST_IDLE, ST_GUARD: begin
        state_d = ST_IDLE;
        if (scan_found_c) begin
          state_d    = ST_GRANT;
          gnt_idx_d  = scan_win_c;
          hold_cnt_d = '0;
        end
      end
      ST_GRANT: begin
        hold_cnt_d = HOLD_W'(hold_cnt_q + HOLD_W'(1));
        if (release_c) begin
          state_d = ST_GUARD;
          ptr_d   = next_idx(gnt_idx_q);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    gnt_valid_d = (state_d == ST_GRANT);
  end

  // Decoder output is registered as the grant vector.
  dec_rr_arbiter_dec4to16 u_dec (
    .w   (gnt_idx_d),
    .en  (gnt_valid_d),
    .y_c (gnt_d)
  );

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      hold_cnt_q  <= '0;
      gnt_idx_q   <= '0;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      hold_cnt_q  <= hold_cnt_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_idx   = gnt_idx_q;
  assign bus.gnt_valid = gnt_valid_q;

endmodule : dec_rr_arbiter

// File: tb/tb_dec_rr_arbiter.sv
// Self-checking bench for dec_rr_arbiter: directed scenarios then random traffic,
// compared against a behavioural owner/ptr model.
module tb_dec_rr_arbiter;

  localparam int N   = 16;
  localparam int MAXH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  dec_rr_arbiter_if bus ();

  dec_rr_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  // Reference model: who owns the resource, how long, and where the scan starts.
  int m_owner = -1;
  int m_held  = 0;
  int m_ptr   = 0;
  int m_idx   = 0;

  function automatic int pick(input logic [15:0] r, input int start);
    for (int k = 0; k < N; k++) begin
      if (r[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_held  = 0;
    m_ptr   = 0;
    m_idx   = 0;
  endtask

  task automatic model_step(input logic [15:0] r, input logic d);
    int w;
    if (m_owner >= 0) begin
      if (d || !r[m_owner] || (MAXH != 0 && m_held + 1 == MAXH)) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end else begin
        m_held++;
      end
    end else begin
      w = pick(r, m_ptr);
      if (w >= 0) begin
        m_owner = w;
        m_idx   = w;
        m_held  = 0;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    logic [31:0] eg;
    eg = (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
    check("gnt", 32'(bus.gnt), eg);
    check("gnt_valid", 32'(bus.gnt_valid), (m_owner >= 0) ? 32'd1 : 32'd0);
    check("gnt_idx", 32'(bus.gnt_idx), 32'(m_idx));
  endtask

  // One clock: model advances on the edge, outputs compared 1ns later.
  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else model_step(bus.req, bus.done);
    #1;
    check_model();
  endtask

  task automatic set_rst(input logic v);
    rst = v;
    if (v) model_reset();
  endtask

  logic [15:0] rq;

  initial begin
    bus.req  = 16'($urandom);
    bus.done = 1'b0;
    set_rst(1'b1);

    // Reset state with random requests applied.
    tick();
    tick();
    check("rst_gnt", 32'(bus.gnt), 32'd0);
    check("rst_idx", 32'(bus.gnt_idx), 32'd0);
    set_rst(1'b0);
    bus.req = 16'h0000;
    tick();

    // Single requester 5: grant, done release, guard, re-grant.
    bus.req = 16'h0020;
    tick();
    check("t2_gnt", 32'(bus.gnt), 32'h0020);
    check("t2_idx", 32'(bus.gnt_idx), 32'd5);
    bus.done = 1'b1;
    tick();
    check("t2_guard", 32'(bus.gnt), 32'd0);
    bus.done = 1'b0;
    tick();
    check("t2_regrant", 32'(bus.gnt_idx), 32'd5);
    bus.req = 16'h0000;
    tick();
    tick();

    // All requesting, done every grant cycle: 0..15 then wrap to 0.
    set_rst(1'b1);
    tick();
    set_rst(1'b0);
    bus.req  = 16'hFFFF;
    bus.done = 1'b1;
    for (int k = 0; k <= N; k++) begin
      tick();
      check("t3_idx", 32'(bus.gnt_idx), 32'(k % N));
      check("t3_valid", 32'(bus.gnt_valid), 32'd1);
      tick();
      check("t3_gap", 32'(bus.gnt), 32'd0);
    end
    bus.req  = 16'h0000;
    bus.done = 1'b0;
    tick();

    // Move ptr to 4 via requester 3, then contend 12 vs 3.
    bus.req = 16'h0008;
    tick();
    bus.done = 1'b1;
    tick();
    bus.req  = 16'h0000;
    bus.done = 1'b0;
    tick();
    bus.req = 16'h1008;
    tick();
    check("t4_first", 32'(bus.gnt_idx), 32'd12);
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    tick();
    check("t4_second", 32'(bus.gnt_idx), 32'd3);
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    tick();
    check("t4_third", 32'(bus.gnt_idx), 32'd12);
    bus.done = 1'b1;
    tick();
    bus.req  = 16'h0000;
    bus.done = 1'b0;
    tick();

    // Hold limit: requester 7 held, no done -> 8 grant cycles, 1 gap.
    bus.req = 16'h0080;
    for (int c = 0; c < MAXH; c++) begin
      tick();
      check("t5_hold", 32'(bus.gnt), 32'h0080);
    end
    tick();
    check("t5_gap", 32'(bus.gnt), 32'd0);
    tick();
    check("t5_regrant", 32'(bus.gnt), 32'h0080);

    // Requester 9: drop request and done together -> single release, ptr=10.
    bus.req = 16'h0200;
    tick();
    tick();
    check("t6_grant9", 32'(bus.gnt_idx), 32'd9);
    bus.req  = 16'h0000;
    bus.done = 1'b1;
    tick();
    check("t6_guard", 32'(bus.gnt), 32'd0);
    bus.req  = 16'h0600;
    bus.done = 1'b0;
    tick();
    check("t6_ptr10", 32'(bus.gnt_idx), 32'd10);
    tick();

    // Asynchronous reset mid-grant, checked before any clock edge.
    set_rst(1'b1);
    #2;
    check("t6_async_gnt", 32'(bus.gnt), 32'd0);
    check("t6_async_valid", 32'(bus.gnt_valid), 32'd0);
    check("t6_async_idx", 32'(bus.gnt_idx), 32'd0);
    tick();
    set_rst(1'b0);
    tick();
    check("t6_ptr0", 32'(bus.gnt_idx), 32'd9);

    // Random traffic with sticky requests, random done and rare resets.
    rq = 16'h0000;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) rq = 16'($urandom) & 16'($urandom);
      bus.req  = rq;
      bus.done = ($urandom_range(0, 3) == 0);
      set_rst($urandom_range(0, 99) == 0);
      tick();
    end
    set_rst(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_dec_rr_arbiter
